rem_ctrl: RTL and testbench

Multi-cycle sequenced signed-remainder unit for the ALU. It accepts a pair of two's-complement operands under a start/done handshake and runs an iterative restoring shift-subtract on operand magnitudes. It then applies the dividend's sign and registers the result with the same DZF/SF/ZF flag set used by the ALU's combinational remainder path. It replaces the single-cycle remainder datapath wherever the ALU is clocked and operand width makes a combinational divider too deep.

---
 rtl/rem_ctrl_if.sv | 25 ++
 rtl/rem_ctrl.sv | 125 ++++++++++++
 tb/tb_rem_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rem_ctrl_if.sv
// Handshake and result bundle for the sequenced signed-remainder unit.
// The master drives the request side and the slave (rem_ctrl) drives the result side.
interface rem_ctrl_if #(
    parameter int W = 3
);
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [W+1:0]   R;
    logic           DZF;
    logic           SF;
    logic           ZF;

    modport master (
        output start, A, B,
        input  busy, done, R, DZF, SF, ZF
    );

    modport slave (
        input  start, A, B,
        output busy, done, R, DZF, SF, ZF
    );
endinterface

// File: rtl/rem_ctrl.sv
// Multi-cycle signed remainder: restoring shift-subtract on operand magnitudes,
// then the dividend's sign is applied and the result is registered with DZF/SF/ZF.
module rem_ctrl #(
    parameter int W = 3
) (
    input  logic        clk,
    input  logic        rst,
    rem_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DIV, SIGN, DONE} state_t;

    localparam int            CW       = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(W);

    state_t          state_q, state_d;
    logic [W+1:0]    p_q, p_d;
    logic [W:0]      a_q, a_d;
    logic [W:0]      b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W+1:0]    r_q, r_d;
    logic            dzf_q, dzf_d;
    logic            sf_q, sf_d;
    logic            zf_q, zf_d;

    // Magnitudes are one bit wider than the operands so -2^(W-1) is representable.
    logic [W:0]      a_ext, b_ext, a_mag, b_mag;
    logic [W+1:0]    p_sh, r_sgn;

    always_comb begin
        a_ext = {bus.A[W-1], bus.A};
        b_ext = {bus.B[W-1], bus.B};
        a_mag = a_ext[W] ? -a_ext : a_ext;
        b_mag = b_ext[W] ? -b_ext : b_ext;
        p_sh  = {p_q[W:0], a_q[W]};
        r_sgn = sgn_q ? -p_q : p_q;
    end

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        dzf_d   = dzf_q;
        sf_d    = sf_q;
        zf_d    = zf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sgn_d = bus.A[W-1];
                    a_d   = a_mag;
                    b_d   = b_mag;
                    if (b_mag == '0) begin
                        r_d     = '0;
                        dzf_d   = 1'b1;
                        sf_d    = 1'b0;
                        zf_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        p_d     = '0;
                        cnt_d   = '0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                p_d = (p_sh >= {1'b0, b_q}) ? (p_sh - {1'b0, b_q}) : p_sh;
                a_d = {a_q[W-1:0], 1'b0};
                if (cnt_q == CNT_LAST) begin
                    state_d = SIGN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SIGN: begin
                r_d     = r_sgn;
                dzf_d   = 1'b0;
                sf_d    = r_sgn[W+1];
                zf_d    = (r_sgn == '0);
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            dzf_q   <= 1'b0;
            sf_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            dzf_q   <= dzf_d;
            sf_q    <= sf_d;
            zf_q    <= zf_d;
        end
    end

    assign bus.busy = (state_q == DIV) || (state_q == SIGN);
    assign bus.done = (state_q == DONE);
    assign bus.R    = r_q;
    assign bus.DZF  = dzf_q;
    assign bus.SF   = sf_q;
    assign bus.ZF   = zf_q;
endmodule

// File: tb/tb_rem_ctrl.sv
// Scoreboard bench for rem_ctrl (W=3): expected results are queued when a request
// is driven and compared, including completion cycle, when done is observed.
module tb_rem_ctrl;
    localparam int W = 3;

    typedef struct {
        logic [W+1:0] r;
        logic         dzf;
        logic         sf;
        logic         zf;
        int           done_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    logic [W+1:0] last_r;
    logic [2:0]   last_flags;

    rem_ctrl_if #(.W(W)) bus ();

    rem_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Truncating remainder: sign follows the dividend; zero divisor flags DZF.
    function automatic exp_t model(input logic [2:0] a, input logic [2:0] b, input int acc);
        exp_t e;
        int   ai, bi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            e.r = '0; e.dzf = 1'b1; e.sf = 1'b0; e.zf = 1'b0;
            e.done_cyc = acc;
        end else begin
            ri = ai % bi;
            e.r = 5'(ri); e.dzf = 1'b0; e.sf = (ri < 0); e.zf = (ri == 0);
            e.done_cyc = acc + W + 2;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'(0));
            end else begin
                e = sb.pop_front();
                check("R",       32'(bus.R),    32'(e.r));
                check("DZF",     32'(bus.DZF),  32'(e.dzf));
                check("SF",      32'(bus.SF),   32'(e.sf));
                check("ZF",      32'(bus.ZF),   32'(e.zf));
                check("busy_in_done", 32'(bus.busy), 32'(0));
                check("latency", 32'(cyc),      32'(e.done_cyc));
                last_r     = e.r;
                last_flags = {e.dzf, e.sf, e.zf};
            end
        end
    end

    task automatic wait_empty(input string tag);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 3 * (W + 4)) begin
            @(negedge clk);
            budget++;
        end
        check(tag, 32'(sb.size()), 32'(0));
        sb.delete();
    endtask

    task automatic do_req(input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        bus.start = 1'b0;
        // Operands must not be re-sampled mid-operation.
        bus.A = 3'($urandom);
        bus.B = 3'($urandom);
        check("busy_after_accept", 32'(bus.busy), 32'(b != 3'b000));
        wait_empty("done_seen");
        repeat (2) begin
            @(negedge clk);
            check("hold_R",     32'(bus.R),                     32'(last_r));
            check("hold_flags", 32'({bus.DZF, bus.SF, bus.ZF}), 32'(last_flags));
        end
    endtask

    initial begin
        int x;
        n_checks   = 0;
        n_fail     = 0;
        last_r     = '0;
        last_flags = '0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        #1;
        check("reset_busy",  32'(bus.busy), 32'(0));
        check("reset_done",  32'(bus.done), 32'(0));
        check("reset_R",     32'(bus.R),    32'(0));
        check("reset_flags", 32'({bus.DZF, bus.SF, bus.ZF}), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_req(3'b011, 3'b110);
        do_req(3'b111, 3'b010);
        do_req(3'b100, 3'b011);
        do_req(3'b100, 3'b111);
        do_req(3'b101, 3'b000);

        // Start held high: back-to-back requests spaced W+4 cycles apart.
        @(negedge clk);
        x = cyc;
        bus.A = 3'd2;
        bus.B = 3'd2;
        bus.start = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(model(3'd2, 3'd2, x + 1 + k * (W + 4)));
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        wait_empty("held_start_done");
        repeat (W + 6) @(negedge clk);

        // Reset mid-DIV aborts without a done pulse.
        do_req(3'b011, 3'b110);
        @(negedge clk);
        bus.A = 3'b011;
        bus.B = 3'b010;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy",  32'(bus.busy), 32'(0));
        check("abort_done",  32'(bus.done), 32'(0));
        check("abort_R",     32'(bus.R),    32'(0));
        check("abort_flags", 32'({bus.DZF, bus.SF, bus.ZF}), 32'(0));
        last_r     = '0;
        last_flags = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 6) @(negedge clk);
        do_req(3'b011, 3'b010);

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                do_req(3'(a), 3'(b));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 100000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
